// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle controller and the MIPS-subset datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if;
    logic       Zero;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       RegWrite;
    logic       MemWrite;
    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [1:0] GPRSel;
    logic [1:0] WDSel;
    logic [3:0] state;

    modport master (
        input  Zero, Op, Funct,
        output RegWrite, MemWrite, PCWrite, IRWrite, IorD, EXTOp, ALUOp,
               ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, state
    );

    modport slave (
        output Zero, Op, Funct,
        input  RegWrite, MemWrite, PCWrite, IRWrite, IorD, EXTOp, ALUOp,
               ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel, state
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: Moore outputs per state, plus the
// Zero-dependent PCWrite in BRANCH.
module mc_ctrl_fsm (
    input logic          clk,
    input logic          rst,
    mc_ctrl_fsm_if.master bus
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRex    = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StIex    = 4'd9,
        StIwb    = 4'd10,
        StJump   = 4'd11,
        StJal    = 4'd12,
        StJr     = 4'd13
    } state_e;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
    localparam logic [5:0] FnSra = 6'b000011;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [3:0] AluPassA = 4'b0000;
    localparam logic [3:0] AluAdd   = 4'b0001;
    localparam logic [3:0] AluSub   = 4'b0010;
    localparam logic [3:0] AluAnd   = 4'b0011;
    localparam logic [3:0] AluOr    = 4'b0100;
    localparam logic [3:0] AluSlt   = 4'b0101;
    localparam logic [3:0] AluLui   = 4'b0110;
    localparam logic [3:0] AluSll   = 4'b1000;
    localparam logic [3:0] AluSrl   = 4'b1001;
    localparam logic [3:0] AluSra   = 4'b1010;

    state_e     r_state;
    state_e     w_state_d;

    logic       w_is_rtype;
    logic       w_funct_ok;
    logic       w_shift;
    logic [3:0] w_rex_aluop;
    logic       w_imm_ok;
    logic       w_imm_ext;
    logic [3:0] w_imm_aluop;

    assign w_is_rtype = (bus.Op == OpRType);

    always_comb begin
        w_funct_ok  = 1'b1;
        w_shift     = 1'b0;
        w_rex_aluop = AluAdd;
        case (bus.Funct)
            FnAdd: w_rex_aluop = AluAdd;
            FnSub: w_rex_aluop = AluSub;
            FnAnd: w_rex_aluop = AluAnd;
            FnOr:  w_rex_aluop = AluOr;
            FnSlt: w_rex_aluop = AluSlt;
            FnSll: begin w_rex_aluop = AluSll; w_shift = 1'b1; end
            FnSrl: begin w_rex_aluop = AluSrl; w_shift = 1'b1; end
            FnSra: begin w_rex_aluop = AluSra; w_shift = 1'b1; end
            default: w_funct_ok = 1'b0;
        endcase
    end

    // andi/ori zero-extend; every other immediate sign-extends.
    always_comb begin
        w_imm_ok    = 1'b1;
        w_imm_ext   = 1'b1;
        w_imm_aluop = AluAdd;
        case (bus.Op)
            OpAddi: w_imm_aluop = AluAdd;
            OpSlti: w_imm_aluop = AluSlt;
            OpAndi: begin w_imm_aluop = AluAnd; w_imm_ext = 1'b0; end
            OpOri:  begin w_imm_aluop = AluOr;  w_imm_ext = 1'b0; end
            OpLui:  w_imm_aluop = AluLui;
            default: w_imm_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d    = StFetch;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.IorD     = 1'b0;
        bus.EXTOp    = 1'b1;
        bus.ALUOp    = AluAdd;
        bus.ALUSrcA  = 2'd0;
        bus.ALUSrcB  = 2'd0;
        bus.PCSource = 2'd0;
        bus.GPRSel   = 2'd0;
        bus.WDSel    = 2'd0;
        case (r_state)
            StFetch: begin
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.PCWrite = 1'b1;
                w_state_d   = StDecode;
            end
            StDecode: begin
                bus.ALUSrcB = 2'd3;
                if (bus.Op == OpLw || bus.Op == OpSw)      w_state_d = StMemAdr;
                else if (w_is_rtype && bus.Funct == FnJr)  w_state_d = StJr;
                else if (w_is_rtype && w_funct_ok)         w_state_d = StRex;
                else if (bus.Op == OpBeq || bus.Op == OpBne) w_state_d = StBranch;
                else if (w_imm_ok)                         w_state_d = StIex;
                else if (bus.Op == OpJ)                    w_state_d = StJump;
                else if (bus.Op == OpJal)                  w_state_d = StJal;
                else                                       w_state_d = StFetch;
            end
            StMemAdr: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                w_state_d   = (bus.Op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                bus.IorD    = 1'b1;
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                w_state_d   = StMemWb;
            end
            StMemWb: begin
                bus.RegWrite = 1'b1;
                bus.GPRSel   = 2'd1;
                bus.WDSel    = 2'd1;
            end
            StMemWr: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                bus.ALUSrcA  = 2'd1;
                bus.ALUSrcB  = 2'd2;
            end
            StRex: begin
                bus.ALUSrcA = w_shift ? 2'd2 : 2'd1;
                bus.ALUOp   = w_rex_aluop;
                w_state_d   = StRwb;
            end
            StRwb: begin
                bus.RegWrite = 1'b1;
            end
            StBranch: begin
                bus.ALUSrcA  = 2'd1;
                bus.ALUOp    = AluSub;
                bus.PCSource = 2'd1;
                bus.PCWrite  = (bus.Op == OpBne) ? ~bus.Zero : bus.Zero;
            end
            StIex: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUSrcB = 2'd2;
                bus.ALUOp   = w_imm_aluop;
                bus.EXTOp   = w_imm_ext;
                w_state_d   = StIwb;
            end
            StIwb: begin
                bus.RegWrite = 1'b1;
                bus.GPRSel   = 2'd1;
                bus.ALUOp    = w_imm_aluop;
                bus.EXTOp    = w_imm_ext;
            end
            StJump: begin
                bus.PCSource = 2'd2;
                bus.PCWrite  = 1'b1;
            end
            StJal: begin
                bus.PCSource = 2'd2;
                bus.PCWrite  = 1'b1;
                bus.RegWrite = 1'b1;
                bus.GPRSel   = 2'd2;
                bus.WDSel    = 2'd2;
            end
            StJr: begin
                bus.ALUSrcA = 2'd1;
                bus.ALUOp   = AluPassA;
                bus.PCWrite = 1'b1;
            end
            default: w_state_d = StFetch;
        endcase
        // Reset suppresses writes in the cycle it is sampled, so an abandoned
        // instruction never commits.
        if (rst) begin
            bus.RegWrite = 1'b0;
            bus.MemWrite = 1'b0;
            bus.PCWrite  = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.IorD     = 1'b0;
            bus.EXTOp    = 1'b1;
            bus.ALUOp    = AluAdd;
            bus.ALUSrcA  = 2'd0;
            bus.ALUSrcB  = 2'd0;
            bus.PCSource = 2'd0;
            bus.GPRSel   = 2'd0;
            bus.WDSel    = 2'd0;
        end
    end

    assign bus.state = r_state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks instruction classes and compares
// state plus every control output against hand-derived vectors.
module tb_mc_ctrl_fsm;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mc_ctrl_fsm_if u_if ();

    mc_ctrl_fsm u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] PA = 4'b0000, AD = 4'b0001, SU = 4'b0010, OR_ = 4'b0100,
                           SL = 4'b1000;

    // {state, RegWrite, MemWrite, PCWrite, IRWrite, IorD, EXTOp, ALUOp,
    //  ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel}
    function automatic logic [23:0] mk(input logic [3:0] st, input logic rw, input logic mw,
                                        input logic pw, input logic iw, input logic iord,
                                        input logic ext, input logic [3:0] op,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] ps, input logic [1:0] gs,
                                        input logic [1:0] wd);
        return {st, rw, mw, pw, iw, iord, ext, op, sa, sb, ps, gs, wd};
    endfunction

    function automatic logic [23:0] obs();
        return {u_if.state, u_if.RegWrite, u_if.MemWrite, u_if.PCWrite, u_if.IRWrite,
                u_if.IorD, u_if.EXTOp, u_if.ALUOp, u_if.ALUSrcA, u_if.ALUSrcB,
                u_if.PCSource, u_if.GPRSel, u_if.WDSel};
    endfunction

    task automatic chk(input string tag, input logic [23:0] exp);
        logic [23:0] o;
        o = obs();
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s observed=%06h expected=%06h", tag, o, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [23:0] v_fetch, v_decode, v_rst;

    initial begin
        total = 0;
        bad   = 0;
        v_fetch  = mk(4'd0, 0, 0, 1, 1, 0, 1, AD, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0);
        v_decode = mk(4'd1, 0, 0, 0, 0, 0, 1, AD, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0);
        v_rst    = mk(4'd0, 0, 0, 0, 0, 0, 1, AD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        rst = 1'b1;
        u_if.Zero  = 1'b0;
        u_if.Op    = 6'b000000;
        u_if.Funct = 6'b000000;

        repeat (3) tick();
        chk("reset_hold", v_rst);
        rst = 1'b0;
        #1;
        chk("first_fetch", v_fetch);

        // lw: 0,1,2,3,4,0
        u_if.Op = 6'b100011;
        tick(); chk("lw_decode", v_decode);
        tick(); chk("lw_memadr", mk(4'd2, 0, 0, 0, 0, 0, 1, AD, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0));
        tick(); chk("lw_memrd",  mk(4'd3, 0, 0, 0, 0, 1, 1, AD, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0));
        tick(); chk("lw_memwb",  mk(4'd4, 1, 0, 0, 0, 0, 1, AD, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1));
        tick(); chk("lw_back",   v_fetch);

        // beq: Zero drives PCWrite combinationally in BRANCH
        u_if.Op = 6'b000100;
        tick(); chk("beq_decode", v_decode);
        tick();
        u_if.Zero = 1'b1; #1;
        chk("beq_z1", mk(4'd8, 0, 0, 1, 0, 0, 1, SU, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0));
        u_if.Zero = 1'b0; #1;
        chk("beq_z0", mk(4'd8, 0, 0, 0, 0, 0, 1, SU, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0));
        tick(); chk("beq_back", v_fetch);

        u_if.Op = 6'b000101;
        tick(); tick();
        u_if.Zero = 1'b1; #1;
        chk("bne_z1", mk(4'd8, 0, 0, 0, 0, 0, 1, SU, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0));
        u_if.Zero = 1'b0; #1;
        chk("bne_z0", mk(4'd8, 0, 0, 1, 0, 0, 1, SU, 2'd1, 2'd0, 2'd1, 2'd0, 2'd0));
        tick(); chk("bne_back", v_fetch);

        // sll
        u_if.Op = 6'b000000; u_if.Funct = 6'b000000;
        tick(); tick();
        chk("sll_rex", mk(4'd6, 0, 0, 0, 0, 0, 1, SL, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0));
        tick(); chk("sll_rwb", mk(4'd7, 1, 0, 0, 0, 0, 1, AD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        tick(); chk("sll_back", v_fetch);

        // sub
        u_if.Funct = 6'b100010;
        tick(); tick();
        chk("sub_rex", mk(4'd6, 0, 0, 0, 0, 0, 1, SU, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        tick(); chk("sub_rwb", mk(4'd7, 1, 0, 0, 0, 0, 1, AD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        tick();

        // jr
        u_if.Funct = 6'b001000;
        tick(); tick();
        chk("jr_exec", mk(4'd13, 0, 0, 1, 0, 0, 1, PA, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0));
        tick(); chk("jr_back", v_fetch);

        // ori: zero-extend, OR
        u_if.Op = 6'b001101;
        tick(); tick();
        chk("ori_iex", mk(4'd9, 0, 0, 0, 0, 0, 0, OR_, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0));
        tick(); chk("ori_iwb", mk(4'd10, 1, 0, 0, 0, 0, 0, OR_, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0));
        tick(); chk("ori_back", v_fetch);

        // jal: 0,1,12,0
        u_if.Op = 6'b000011;
        tick(); chk("jal_decode", v_decode);
        tick(); chk("jal_exec", mk(4'd12, 1, 0, 1, 0, 0, 1, AD, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2));
        tick(); chk("jal_back", v_fetch);

        // illegal: 0,1,0
        u_if.Op = 6'b111111;
        tick(); chk("ill_decode", v_decode);
        tick(); chk("ill_back", v_fetch);

        // sw interrupted by reset in MEMWR
        u_if.Op = 6'b101011;
        tick(); tick();
        tick(); chk("sw_memwr", mk(4'd5, 0, 1, 0, 0, 1, 1, AD, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0));
        rst = 1'b1; #1;
        chk("sw_rst_gate", mk(4'd5, 0, 0, 0, 0, 0, 1, AD, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0));
        tick(); chk("sw_rst_state", v_rst);
        rst = 1'b0; #1;
        chk("post_rst_fetch", v_fetch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
